// File: rtl/aoc_line_parser.sv
`default_nettype none
// ============================================================================
// Module   : aoc_line_parser
// Purpose  : Decodes "R<n>\n" / "L<n>\n" ASCII lines into dial-solver moves,
//            one valid pulse per line followed by a fixed quiet gap.
// Option   : AOC_PARSER_CR_EN - silently consume '\r' (CRLF input).
// Revision : 1.0 - initial release
// ============================================================================
module aoc_line_parser #(
  parameter int GAP_CYCLES  = 2000,
  parameter int COUNT_WIDTH = 10,
  parameter int LINE_WIDTH  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   step_direction,
  output logic [COUNT_WIDTH-1:0] step_count,
  output logic                   valid,
  output logic                   error,
  output logic [LINE_WIDTH-1:0]  line_count
);

  localparam int C_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [C_GAP_W-1:0] C_GAP_LOAD =
    C_GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam int C_EXT_W = COUNT_WIDTH + 4;
  localparam logic [C_EXT_W-1:0] C_ACC_MAX = {4'b0000, {COUNT_WIDTH{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIGITS = 3'd1,
    S_SKIP   = 3'd2,
    S_SETUP  = 3'd3,
    S_EMIT   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_dir_pend;
  logic [COUNT_WIDTH-1:0] r_acc;
  logic                   r_has_digit;
  logic                   r_step_dir;
  logic [COUNT_WIDTH-1:0] r_step_count;
  logic                   r_error;
  logic [LINE_WIDTH-1:0]  r_line_count;
  logic [C_GAP_W-1:0]     r_gap_cnt;

  logic                   w_fire;
  logic                   w_is_nl;
  logic                   w_is_cr;
  logic                   w_is_r;
  logic                   w_is_l;
  logic                   w_is_digit;
  logic [C_EXT_W-1:0]     w_acc_ext;
  logic [COUNT_WIDTH-1:0] w_acc_sat;

  logic                   w_start_line;
  logic                   w_acc_en;
  logic                   w_set_err;
  logic                   w_load_out;
  logic                   w_line_inc;
  logic                   w_gap_load;

  assign in_ready = (r_state == S_IDLE) || (r_state == S_DIGITS) || (r_state == S_SKIP);
  assign w_fire   = in_valid && in_ready;

  assign w_is_nl    = (in_data == 8'h0A);
  assign w_is_r     = (in_data == 8'h52);
  assign w_is_l     = (in_data == 8'h4C);
  assign w_is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
`ifdef AOC_PARSER_CR_EN
  assign w_is_cr    = (in_data == 8'h0D);
`else
  assign w_is_cr    = 1'b0;
`endif

  // acc*10 + d in a widened word so the saturation compare sees the overflow
  assign w_acc_ext = ({4'b0000, r_acc} << 3) + ({4'b0000, r_acc} << 1)
                   + C_EXT_W'(in_data[3:0]);
  assign w_acc_sat = (w_acc_ext > C_ACC_MAX) ? {COUNT_WIDTH{1'b1}}
                                             : w_acc_ext[COUNT_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start_line = 1'b0;
    w_acc_en     = 1'b0;
    w_set_err    = 1'b0;
    w_load_out   = 1'b0;
    w_line_inc   = 1'b0;
    w_gap_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fire && !w_is_nl && !w_is_cr) begin
          if (w_is_r || w_is_l) begin
            w_start_line = 1'b1;
            w_next_state = S_DIGITS;
          end else begin
            w_set_err    = 1'b1;
            w_next_state = S_SKIP;
          end
        end
      end
      S_DIGITS: begin
        if (w_fire && !w_is_cr) begin
          if (w_is_digit) begin
            w_acc_en = 1'b1;
          end else if (w_is_nl && r_has_digit) begin
            w_load_out   = 1'b1;
            w_next_state = S_SETUP;
          end else if (w_is_nl) begin
            w_set_err    = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_set_err    = 1'b1;
            w_next_state = S_SKIP;
          end
        end
      end
      S_SKIP: begin
        if (w_fire && w_is_nl) begin
          w_next_state = S_IDLE;
        end
      end
      S_SETUP: begin
        w_next_state = S_EMIT;
      end
      S_EMIT: begin
        w_line_inc = 1'b1;
        if (GAP_CYCLES == 0) begin
          w_next_state = S_IDLE;
        end else begin
          w_gap_load   = 1'b1;
          w_next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir_pend   <= 1'b0;
      r_acc        <= '0;
      r_has_digit  <= 1'b0;
      r_step_dir   <= 1'b0;
      r_step_count <= '0;
      r_error      <= 1'b0;
      r_line_count <= '0;
      r_gap_cnt    <= '0;
    end else begin
      if (w_start_line) begin
        r_dir_pend  <= w_is_r;
        r_acc       <= '0;
        r_has_digit <= 1'b0;
      end else if (w_acc_en) begin
        r_acc       <= w_acc_sat;
        r_has_digit <= 1'b1;
      end
      if (w_load_out) begin
        r_step_dir   <= r_dir_pend;
        r_step_count <= r_acc;
      end
      if (w_set_err) begin
        r_error <= 1'b1;
      end
      if (w_line_inc) begin
        r_line_count <= r_line_count + LINE_WIDTH'(1);
      end
      if (w_gap_load) begin
        r_gap_cnt <= C_GAP_LOAD;
      end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - C_GAP_W'(1);
      end
    end
  end

  assign valid          = (r_state == S_EMIT);
  assign step_direction = r_step_dir;
  assign step_count     = r_step_count;
  assign error          = r_error;
  assign line_count     = r_line_count;

endmodule
`default_nettype wire

// File: tb/tb_aoc_line_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_aoc_line_parser
// Purpose  : Self-checking bench for aoc_line_parser (table of whole-line
//            vectors plus hand-written timing and reset-in-gap sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aoc_line_parser;

  localparam int GAP = 2000;
  localparam int CW  = 10;
  localparam int LW  = 12;
  localparam int TMO = 5000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          step_direction;
  logic [CW-1:0] step_count;
  logic          valid;
  logic          error;
  logic [LW-1:0] line_count;

  int n_checks = 0;
  int n_errors = 0;

  aoc_line_parser #(.GAP_CYCLES(GAP), .COUNT_WIDTH(CW), .LINE_WIDTH(LW)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .step_direction (step_direction),
    .step_count     (step_count),
    .valid          (valid),
    .error          (error),
    .line_count     (line_count)
  );

  always #5 clk = ~clk;

  // Pulse monitor: records each move and flags wide pulses or data that
  // changed between SETUP and EMIT.
  logic          mon_dir[$];
  logic [CW-1:0] mon_cnt[$];
  int            mon_bad = 0;
  logic          prev_valid = 1'b0;
  logic          prev_dir = 1'b0;
  logic [CW-1:0] prev_cnt = '0;

  always @(negedge clk) begin
    if (valid) begin
      mon_dir.push_back(step_direction);
      mon_cnt.push_back(step_count);
      if (prev_valid) mon_bad++;
      if (prev_dir != step_direction || prev_cnt != step_count) mon_bad++;
    end
    prev_valid = valid;
    prev_dir   = step_direction;
    prev_cnt   = step_count;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input byte b);
    int t = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready) begin
      if (t >= TMO) begin
        check("send_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      t++;
    end
    @(posedge clk);
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    string         line;
    int            pulses;
    logic          first_dir;
    logic [CW-1:0] first_cnt;
    logic          last_dir;
    logic [CW-1:0] last_cnt;
    logic          err;
    int            lc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int base;
    int bad0;
    int lowcnt;
    int np;

    vecs[0] = '{"R12\n",       1, 1'b1, 10'd12,  1'b1, 10'd12,   1'b0, 1};
    vecs[1] = '{"L0\n\nL999\n", 2, 1'b0, 10'd0,   1'b0, 10'd999,  1'b0, 2};
    vecs[2] = '{"R99999\n",    1, 1'b1, 10'd1023, 1'b1, 10'd1023, 1'b0, 1};
    vecs[3] = '{"X5\nR\nL3\n", 1, 1'b0, 10'd3,   1'b0, 10'd3,    1'b1, 1};
`ifdef AOC_PARSER_CR_EN
    vecs[4] = '{"R1\r\n",      1, 1'b1, 10'd1,   1'b1, 10'd1,    1'b0, 1};
`else
    vecs[4] = '{"R1\r\n",      0, 1'b0, 10'd0,   1'b0, 10'd0,    1'b1, 0};
`endif
    vecs[5] = '{"L7\n",        1, 1'b0, 10'd7,   1'b0, 10'd7,    1'b0, 1};
    vecs[6] = '{"R1X\nR4\n",   1, 1'b1, 10'd4,   1'b1, 10'd4,    1'b1, 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",   int'(in_ready),       1);
    check("rst_valid",      int'(valid),          0);
    check("rst_dir",        int'(step_direction), 0);
    check("rst_count",      int'(step_count),     0);
    check("rst_error",      int'(error),          0);
    check("rst_line_count", int'(line_count),     0);

    // Table-driven whole-line vectors, each from a fresh reset
    for (int v = 0; v < 7; v++) begin
      do_reset();
      base = mon_dir.size();
      bad0 = mon_bad;
      send_line(vecs[v].line);
      repeat (GAP + 20) @(negedge clk);
      np = mon_dir.size() - base;
      check($sformatf("v%0d_pulses", v), np, vecs[v].pulses);
      check($sformatf("v%0d_error", v), int'(error), int'(vecs[v].err));
      check($sformatf("v%0d_line_count", v), int'(line_count), vecs[v].lc);
      check($sformatf("v%0d_pulse_shape", v), mon_bad - bad0, 0);
      if (vecs[v].pulses > 0 && np == vecs[v].pulses) begin
        check($sformatf("v%0d_first_dir", v), int'(mon_dir[base]), int'(vecs[v].first_dir));
        check($sformatf("v%0d_first_cnt", v), int'(mon_cnt[base]), int'(vecs[v].first_cnt));
        check($sformatf("v%0d_last_dir", v), int'(mon_dir[base+np-1]), int'(vecs[v].last_dir));
        check($sformatf("v%0d_last_cnt", v), int'(mon_cnt[base+np-1]), int'(vecs[v].last_cnt));
      end
    end

    // Cycle-exact timing of a single line
    do_reset();
    send_byte("R");
    send_byte("1");
    send_byte("2");
    send_byte("\n");
    @(negedge clk);
    in_valid = 1'b0;
    check("t_setup_valid", int'(valid),          0);
    check("t_setup_ready", int'(in_ready),       0);
    check("t_setup_dir",   int'(step_direction), 1);
    check("t_setup_cnt",   int'(step_count),     12);
    @(negedge clk);
    check("t_emit_valid",  int'(valid),          1);
    lowcnt = 2;
    @(negedge clk);
    check("t_after_valid", int'(valid),          0);
    while (!in_ready && lowcnt < TMO) begin
      lowcnt++;
      @(negedge clk);
    end
    check("t_ready_low_cycles", lowcnt, GAP + 2);
    check("t_line_count",  int'(line_count),     1);

    // Reset asserted inside the gap with a byte held on the input
    do_reset();
    send_line("L3\n");
    repeat (100) @(negedge clk);
    in_data  = "R";
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("g_held_no_xfer_err", int'(error),      0);
    check("g_held_ready",       int'(in_ready),   0);
    check("g_line_count",       int'(line_count), 1);
    rst = 1'b1;
    #1;
    check("g_rst_valid",  int'(valid),          0);
    check("g_rst_ready",  int'(in_ready),       1);
    check("g_rst_lc",     int'(line_count),     0);
    check("g_rst_cnt",    int'(step_count),     0);
    check("g_rst_dir",    int'(step_direction), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("g_release_ready", int'(in_ready), 1);
    base = mon_dir.size();
    send_byte("5");
    send_byte("\n");
    @(negedge clk);
    in_valid = 1'b0;
    repeat (GAP + 20) @(negedge clk);
    np = mon_dir.size() - base;
    check("g_pulses", np, 1);
    if (np == 1) begin
      check("g_dir", int'(mon_dir[base]), 1);
      check("g_cnt", int'(mon_cnt[base]), 5);
    end
    check("g_error",      int'(error),      0);
    check("g_line_count_after", int'(line_count), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
